alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Command-side initiator for the 16-bit combinational ALU. It accepts operation requests over a valid/ready command channel and drives registered operands and opcode into the ALU. It captures the ALU result and flags, then returns them over a valid/ready response channel. A result accumulator lets commands chain, using the previous result as operand A.

## Interface
Parameters:
- ACC_RESET, 16'h0000, reset and clear value of the accumulator
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  16  operand A; ignored when cmd_use_acc=1
- cmd_b  in  16  operand B
- cmd_op  in  alu_op_t  requested operation
- cmd_use_acc  in  1  substitute the accumulator for A
- acc_clr  in  1  synchronous accumulator clear
- alu_a / alu_b  out  16 each  registered operands to the ALU
- alu_op  out  alu_op_t  registered opcode to the ALU
- alu_result  in  16  ALU result
- alu_carry / alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  16  captured result
- rsp_carry / rsp_zero / rsp_err  out  1 each  captured flags and illegal-op error
- op_count  out  CNT_W  number of completed legal operations; wraps

## Operation
FSM states are IDLE, EXEC and RESP.
- **IDLE:** cmd_ready=1. On cmd_valid&&cmd_ready:
  - Register alu_a (cmd_use_acc ? acc : cmd_a), alu_b=cmd_b and alu_op=cmd_op.
  - A legal op goes to EXEC.
  - An illegal encoding (3'd7) goes directly to RESP with rsp_err=1, rsp_result=0, rsp_carry=0, rsp_zero=0. The accumulator and op_count are unchanged.
- **EXEC:** one cycle for the ALU to settle on the registered inputs. At the end of EXEC:
  - Capture alu_result, alu_carry and alu_zero into the rsp_* registers; rsp_err=0.
  - acc <= alu_result; op_count += 1, wrapping from 2^CNT_W-1 to 0.
  - Go to RESP.
- **RESP:** rsp_valid=1. All rsp_* outputs hold stable until rsp_valid&&rsp_ready, then go to IDLE. cmd_ready=0 in EXEC and RESP.

Other rules:
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- acc_clr sets acc=ACC_RESET in any state. If it coincides with the EXEC capture, the clear wins.
- cmd_use_acc uses the acc value present in the accept cycle. A clear in that same cycle does not affect the operand taken.
- Flags are passed through from the ALU and never recomputed. The carry is bit 16 of the 17-bit sum or difference (borrow for SUB). The carry is 0 for logic and shift ops.

## Timing
- Reset values: state=IDLE, cmd_ready=1 (combinational from state), rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=ADD, acc=ACC_RESET, op_count=0.
- Legal op: accepted at edge N; rsp_valid is high after edge N+2.
- Illegal op: rsp_valid is high after edge N+1.
- Minimum spacing between accepted commands is 3 cycles (legal) or 2 cycles (illegal), given rsp_ready=1.
- Reset asserted in any state returns to the reset values immediately. Any in-flight command and any pending response are discarded.
- No combinational path from cmd_* or rsp_ready to rsp_*. The cmd_ready path is state-only.

## Structure
- alu_pkg holds:
  - alu_op_t, a 3-bit enum: ADD=0, SUB=1, AND_OP=2, OR_OP=3, XOR_OP=4, SHIFT_LEFT=5, SHIFT_RIGHT=6.
  - An ALU_OP_ILLEGAL=3'd7 constant.
  - The sequencer state enum seq_state_t.
- Single module; no sub-module. The ALU is instantiated beside the sequencer at the level above, and the testbench connects the pair.

## Test plan
- **ADD with carry:** A=16'hFFFF, B=16'h0001 -> rsp_result=16'h0000, carry=1, zero=1, err=0; rsp_valid two edges after accept; op_count=1.
- **SUB with borrow:** A=16'h0003, B=16'h0005 -> rsp_result=16'hFFFE, carry=1, zero=0.
- **Chained ops and clear:**
  - ADD 5+7 -> result 16'h000C.
  - Then cmd_use_acc=1, ADD B=1 -> result 16'h000D.
  - acc_clr, then cmd_use_acc=1, OR B=16'h00F0 -> result 16'h00F0.
- **Shift and zero flag:** SHIFT_LEFT A=16'h0001, B=16'h0010 -> result 16'h0000, zero=1, carry=0.
- **Backpressure and illegal op:**
  - Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout.
  - cmd_op=3'd7 -> err=1, result 0, acc and op_count unchanged, response one edge after accept.
- **Reset mid-operation:** deassert rst_n during EXEC -> all outputs return to reset values at once, and no response is produced after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU and its command sequencer: opcode encoding,
// the reserved illegal opcode and the sequencer state machine encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD         = 3'd0,
        SUB         = 3'd1,
        AND_OP      = 3'd2,
        OR_OP       = 3'd3,
        XOR_OP      = 3'd4,
        SHIFT_LEFT  = 3'd5,
        SHIFT_RIGHT = 3'd6
    } alu_op_t;

    localparam logic [2:0] ALU_OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic is_illegal_op(input alu_op_t op);
        return (3'(op) == ALU_OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the 16-bit combinational ALU: registers operands,
// waits one cycle for the ALU to settle, and returns result/flags on a response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter logic [15:0] ACC_RESET = 16'h0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  alu_op_t          cmd_op,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,

    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output alu_op_t          alu_op,
    input  logic [15:0]      alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,

    output logic [CNT_W-1:0] op_count
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [15:0] acc;
    logic        accept;
    logic        accept_illegal;

    assign cmd_ready      = (state == IDLE);
    assign rsp_valid      = (state == RESP);
    assign accept         = cmd_valid && cmd_ready;
    assign accept_illegal = accept && is_illegal_op(cmd_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = accept_illegal ? RESP : EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers only move on accept, so the ALU inputs hold between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= 16'h0000;
            alu_b  <= 16'h0000;
            alu_op <= ADD;
        end else if (accept) begin
            alu_a  <= cmd_use_acc ? acc : cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= 16'h0000;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept_illegal) begin
            rsp_result <= 16'h0000;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
        end
    end

    // A clear takes priority over the EXEC write-back of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_RESET;
        end else if (acc_clr) begin
            acc <= ACC_RESET;
        end else if (state == EXEC) begin
            acc <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (state == EXEC) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
